// File: rtl/usr_pkg.sv
// usr_pkg: shared types and constants for the universal shift register.
//   MODE_*  : encodings of the 2-bit mode input S
//   state_e : burst controller states (IDLE, BURST)
//   dir_e   : latched burst shift direction
//   cmd_e   : effective per-edge command handed from the controller to the datapath
package usr_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_e;

   typedef enum logic [1:0] {
      CMD_HOLD = 2'b00,
      CMD_SHR  = 2'b01,
      CMD_SHL  = 2'b10,
      CMD_LOAD = 2'b11
   } cmd_e;

   // Map a raw mode value onto the datapath command.
   function automatic cmd_e mode_to_cmd(input logic [1:0] mode);
      cmd_e cmd;
      case (mode)
         MODE_SHR:  cmd = CMD_SHR;
         MODE_SHL:  cmd = CMD_SHL;
         MODE_LOAD: cmd = CMD_LOAD;
         default:   cmd = CMD_HOLD;
      endcase
      return cmd;
   endfunction

   // Direction latched for a burst given a shifting mode.
   function automatic dir_e mode_to_dir(input logic [1:0] mode);
      return (mode == MODE_SHL) ? DIR_LEFT : DIR_RIGHT;
   endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control/data bus of the universal shift register.
//   S, D, SR, SL, START, CNT (and ROT when USR_ROTATE_EN is defined) : requests
//   Q, Qbar, BUSY, DONE                                              : register state
// Modports: master drives requests and observes state; slave is the register.
interface univ_shift_reg_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = 4
);

   logic [1:0]       S;
   logic [WIDTH-1:0] D;
   logic             SR;
   logic             SL;
   logic             START;
   logic [CW-1:0]    CNT;
`ifdef USR_ROTATE_EN
   logic             ROT;
`endif
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Qbar;
   logic             BUSY;
   logic             DONE;

`ifdef USR_ROTATE_EN
   modport master (output S, D, SR, SL, START, CNT, ROT,
                   input  Q, Qbar, BUSY, DONE);
   modport slave  (input  S, D, SR, SL, START, CNT, ROT,
                   output Q, Qbar, BUSY, DONE);
`else
   modport master (output S, D, SR, SL, START, CNT,
                   input  Q, Qbar, BUSY, DONE);
   modport slave  (input  S, D, SR, SL, START, CNT,
                   output Q, Qbar, BUSY, DONE);
`endif

endinterface

// File: rtl/usr_burst_ctl.sv
// usr_burst_ctl: IDLE/BURST controller of the universal shift register.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   mode_i     : raw mode S
//   start_i    : burst request, honoured in IDLE only
//   cnt_i      : burst length in shifts
//   cmd_c_o    : effective command for this edge (combinational)
//   busy_o     : high while a burst runs
//   done_o     : one-cycle pulse after the final burst shift
module usr_burst_ctl
   import usr_pkg::*;
#(
   parameter int unsigned CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    mode_i,
   input  logic          start_i,
   input  logic [CW-1:0] cnt_i,
   output cmd_e          cmd_c_o,
   output logic          busy_o,
   output logic          done_o
);

   state_e        state_q, state_d;
   dir_e          dir_q, dir_d;
   logic [CW-1:0] remain_q, remain_d;
   logic          done_q, done_d;
   logic          accept_c;

   // A burst only starts for a shifting mode with a non-zero length.
   assign accept_c = start_i && ((mode_i == MODE_SHR) || (mode_i == MODE_SHL))
                     && (cnt_i != '0);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         dir_q    <= DIR_RIGHT;
         remain_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         remain_q <= remain_d;
         done_q   <= done_d;
      end
   end

   // Next state and effective command.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      remain_d = remain_q;
      done_d   = 1'b0;
      cmd_c_o  = CMD_HOLD;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               // Q holds on the accepting edge; shifting starts next edge.
               dir_d    = mode_to_dir(mode_i);
               remain_d = cnt_i;
               state_d  = BURST;
            end else begin
               cmd_c_o = mode_to_cmd(mode_i);
            end
         end
         BURST: begin
            cmd_c_o  = (dir_q == DIR_LEFT) ? CMD_SHL : CMD_SHR;
            remain_d = remain_q - CW'(1);
            // Exit on remain==1 so the counter never wraps.
            if (remain_q == CW'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy_o = (state_q == BURST);
   assign done_o = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register with burst mode.
//   C   : clock, rising edge active
//   R   : asynchronous active-high reset
//   bus : univ_shift_reg_if.slave (S, D, SR, SL, START, CNT, [ROT] in;
//         Q, Qbar, BUSY, DONE out)
// Optional feature: define USR_ROTATE_EN to add the ROT input, which wraps
// the outgoing bit back in place of SR/SL on any shifting edge.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = 4
) (
   input  logic          C,
   input  logic          R,
   univ_shift_reg_if.slave bus
);

   logic [WIDTH-1:0] q_q, q_d;
   cmd_e             cmd;
   logic             busy;
   logic             done;
   logic             sr_bit;
   logic             sl_bit;

   usr_burst_ctl #(
      .CW (CW)
   ) u_burst_ctl (
      .clk     (C),
      .rst     (R),
      .mode_i  (bus.S),
      .start_i (bus.START),
      .cnt_i   (bus.CNT),
      .cmd_c_o (cmd),
      .busy_o  (busy),
      .done_o  (done)
   );

   // Serial input selection: external bit, or wrapped bit when rotating.
`ifdef USR_ROTATE_EN
   always_comb begin
      sr_bit = bus.SR;
      sl_bit = bus.SL;
      if (bus.ROT) begin
         sr_bit = q_q[0];
         sl_bit = q_q[WIDTH-1];
      end
   end
`else
   always_comb begin
      sr_bit = bus.SR;
      sl_bit = bus.SL;
   end
`endif

   // Datapath next value.
   always_comb begin
      q_d = q_q;
      case (cmd)
         CMD_SHR:  q_d = {sr_bit, q_q[WIDTH-1:1]};
         CMD_SHL:  q_d = {q_q[WIDTH-2:0], sl_bit};
         CMD_LOAD: q_d = bus.D;
         default:  q_d = q_q;
      endcase
   end

   // Q register.
   always_ff @(posedge C or posedge R) begin
      if (R) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   // Qbar is a pure inversion of the Q flops so both move on the same edge.
   assign bus.Q    = q_q;
   assign bus.Qbar = ~q_q;
   assign bus.BUSY = busy;
   assign bus.DONE = done;

endmodule
